// File: rtl/alu_result_fifo.sv
// alu_result_fifo: show-ahead FIFO buffering ALU {status, result} pairs with a valid/ready output.
// Ports: i_clk/i_reset (sync, active-high); i_result/i_status/i_valid push side with o_ready (not full);
// o_result/o_status/o_valid head entry popped by i_ready; o_level entry count; o_drop_cnt refused pushes;
// o_flag_cnt accepted nonzero-status pushes, present only when ALU_RESULT_FIFO_FLAG_CNT_EN is defined.
module alu_result_fifo #(
    parameter int M     = 4,
    parameter int DEPTH = 4,
    parameter int CNT_W = 8
) (
    input  logic                     i_clk,
    input  logic                     i_reset,
    input  logic [M-1:0]             i_result,
    input  logic [3:0]               i_status,
    input  logic                     i_valid,
    output logic                     o_ready,
    output logic [M-1:0]             o_result,
    output logic [3:0]               o_status,
    output logic                     o_valid,
    input  logic                     i_ready,
    output logic [$clog2(DEPTH):0]   o_level,
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
    output logic [CNT_W-1:0]         o_flag_cnt,
`endif
    output logic [CNT_W-1:0]         o_drop_cnt
);
    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [M+3:0]  mem [DEPTH];
    logic [M+3:0]  head;
    logic [AW-1:0] rd_ptr, wr_ptr, rd_nxt;
    logic [LW-1:0] level, level_nxt;
    logic          push, pop;

    assign o_valid   = level != '0;
    assign o_ready   = level != LW'(DEPTH);
    assign push      = i_valid && o_ready;
    assign pop       = o_valid && i_ready;
    assign rd_nxt    = pop ? rd_ptr + AW'(1) : rd_ptr;
    assign level_nxt = level + LW'(push) - LW'(pop);
    assign {o_status, o_result} = head;
    assign o_level   = level;

    always_ff @(posedge i_clk)
        if (push) mem[wr_ptr] <= {i_status, i_result};

    // Head is registered so it holds the last popped entry while empty; when the
    // next head slot is being written this cycle, take the incoming data directly.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            level      <= '0;
            head       <= '0;
            o_drop_cnt <= '0;
        end else begin
            rd_ptr <= rd_nxt;
            level  <= level_nxt;
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (level_nxt != '0)
                head <= (push && rd_nxt == wr_ptr) ? {i_status, i_result} : mem[rd_nxt];
            if (i_valid && !o_ready && o_drop_cnt != '1)
                o_drop_cnt <= o_drop_cnt + CNT_W'(1);
        end
    end

`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
    always_ff @(posedge i_clk) begin
        if (i_reset)
            o_flag_cnt <= '0;
        else if (push && i_status != 4'd0 && o_flag_cnt != '1)
            o_flag_cnt <= o_flag_cnt + CNT_W'(1);
    end
`endif
endmodule

// File: tb/tb_alu_result_fifo.sv
// tb_alu_result_fifo: table-driven, directed and randomized checks of alu_result_fifo against a queue model.
module tb_alu_result_fifo;
    localparam int M     = 4;
    localparam int DEPTH = 4;
    localparam int CNT_W = 8;
    localparam int SAT   = 2**CNT_W - 1;

    logic                   i_clk = 1'b0;
    logic                   i_reset, i_valid, i_ready, o_ready, o_valid;
    logic [M-1:0]           i_result, o_result;
    logic [3:0]             i_status, o_status;
    logic [$clog2(DEPTH):0] o_level;
    logic [CNT_W-1:0]       o_drop_cnt;
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
    logic [CNT_W-1:0]       o_flag_cnt;
`endif

    always #5 i_clk = ~i_clk;

    alu_result_fifo #(.M(M), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .i_clk(i_clk), .i_reset(i_reset), .i_result(i_result), .i_status(i_status),
        .i_valid(i_valid), .o_ready(o_ready), .o_result(o_result), .o_status(o_status),
        .o_valid(o_valid), .i_ready(i_ready), .o_level(o_level),
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
        .o_flag_cnt(o_flag_cnt),
`endif
        .o_drop_cnt(o_drop_cnt)
    );

    typedef struct {
        logic v, r;
        logic [M-1:0] res;
        logic [3:0] st;
        int lvl;
        logic val, rdy;
        logic [M-1:0] eres;
        logic [3:0] est;
        int drop, flag;
    } vec_t;

    int n_chk = 0, n_fail = 0;
    logic [M+3:0] q[$];
    int drops = 0, flags = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Drives one cycle, advances the reference queue model, samples 1ns after the edge.
    task automatic cyc(input logic rst, input logic v, input logic r,
                       input logic [M-1:0] res, input logic [3:0] st);
        bit full, take;
        i_reset = rst; i_valid = v; i_ready = r; i_result = res; i_status = st;
        if (rst) begin
            q.delete(); drops = 0; flags = 0;
        end else begin
            full = q.size() == DEPTH;
            take = r && q.size() != 0;
            if (v && full && drops < SAT) drops++;
            if (take) void'(q.pop_front());
            if (v && !full) begin
                q.push_back({st, res});
                if (st != 0 && flags < SAT) flags++;
            end
        end
        @(posedge i_clk);
        #1;
        i_reset = 1'b0;
    endtask

    task automatic check_model(input string tag);
        chk({tag, " level"}, 32'(o_level), q.size());
        chk({tag, " valid"}, 32'(o_valid), 32'(q.size() != 0));
        chk({tag, " ready"}, 32'(o_ready), 32'(q.size() != DEPTH));
        chk({tag, " drop"}, 32'(o_drop_cnt), drops);
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
        chk({tag, " flag"}, 32'(o_flag_cnt), flags);
`endif
        if (q.size() != 0) chk({tag, " head"}, 32'({o_status, o_result}), 32'(q[0]));
    endtask

    task automatic check_reset(input string tag);
        chk({tag, " level"}, 32'(o_level), 0);
        chk({tag, " valid"}, 32'(o_valid), 0);
        chk({tag, " ready"}, 32'(o_ready), 1);
        chk({tag, " drop"}, 32'(o_drop_cnt), 0);
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
        chk({tag, " flag"}, 32'(o_flag_cnt), 0);
`endif
    endtask

    vec_t tbl[11];

    initial begin
        tbl[0]  = '{1, 0,  3, 0, 1, 1, 1,  3, 0, 0, 0};
        tbl[1]  = '{1, 0,  7, 1, 2, 1, 1,  3, 0, 0, 1};
        tbl[2]  = '{1, 0, 12, 0, 3, 1, 1,  3, 0, 0, 1};
        tbl[3]  = '{1, 0,  4, 2, 4, 1, 0,  3, 0, 0, 2};
        tbl[4]  = '{1, 0,  9, 5, 4, 1, 0,  3, 0, 1, 2};
        tbl[5]  = '{1, 0,  9, 5, 4, 1, 0,  3, 0, 2, 2};
        tbl[6]  = '{1, 0,  9, 5, 4, 1, 0,  3, 0, 3, 2};
        tbl[7]  = '{1, 1,  9, 5, 3, 1, 1,  7, 1, 4, 2};
        tbl[8]  = '{0, 1,  0, 0, 2, 1, 1, 12, 0, 4, 2};
        tbl[9]  = '{0, 1,  0, 0, 1, 1, 1,  4, 2, 4, 2};
        tbl[10] = '{0, 1,  0, 0, 0, 0, 1,  0, 0, 4, 2};

        i_reset = 1'b0; i_valid = 1'b0; i_ready = 1'b0; i_result = '0; i_status = '0;
        cyc(1, 0, 0, 0, 0);
        check_reset("reset");
        chk("reset result", 32'(o_result), 0);
        chk("reset status", 32'(o_status), 0);

        // fill, overflow, full push+pop, drain
        for (int i = 0; i < 11; i++) begin
            cyc(0, tbl[i].v, tbl[i].r, tbl[i].res, tbl[i].st);
            chk($sformatf("vec%0d level", i), 32'(o_level), tbl[i].lvl);
            chk($sformatf("vec%0d valid", i), 32'(o_valid), 32'(tbl[i].val));
            chk($sformatf("vec%0d ready", i), 32'(o_ready), 32'(tbl[i].rdy));
            chk($sformatf("vec%0d drop", i), 32'(o_drop_cnt), tbl[i].drop);
`ifdef ALU_RESULT_FIFO_FLAG_CNT_EN
            chk($sformatf("vec%0d flag", i), 32'(o_flag_cnt), tbl[i].flag);
`endif
            if (tbl[i].val) begin
                chk($sformatf("vec%0d result", i), 32'(o_result), 32'(tbl[i].eres));
                chk($sformatf("vec%0d status", i), 32'(o_status), 32'(tbl[i].est));
            end
        end

        // level 2 sustained push+pop
        cyc(0, 1, 0, 1, 0);
        cyc(0, 1, 0, 2, 3);
        for (int i = 0; i < 10; i++) begin
            cyc(0, 1, 1, 4'(i + 3), 4'(i));
            check_model("lvl2");
        end
        cyc(0, 0, 1, 0, 0);
        cyc(0, 0, 1, 0, 0);
        check_model("lvl2 drained");

        // wrap-around at level 1: values 0..10 in order
        cyc(0, 1, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            cyc(0, 1, 1, 4'(i), 4'(i & 3));
            chk($sformatf("wrap head %0d", i), 32'(o_result), i);
            check_model("wrap");
        end
        cyc(0, 0, 1, 0, 0);
        check_model("wrap drained");

        // reset mid-operation with push and pop requested
        cyc(0, 1, 0, 5, 1);
        cyc(0, 1, 0, 6, 0);
        cyc(0, 1, 0, 7, 2);
        cyc(1, 1, 1, 8, 8);
        check_reset("midreset");
        cyc(0, 1, 0, 6, 3);
        chk("post-reset level", 32'(o_level), 1);
        chk("post-reset head", 32'({o_status, o_result}), 32'({4'd3, 4'd6}));

        // drop counter saturation
        for (int i = 0; i < 3; i++) cyc(0, 1, 0, 4'(i), 0);
        for (int i = 0; i < SAT + 5; i++) cyc(0, 1, 0, 9, 9);
        chk("drop saturate", 32'(o_drop_cnt), SAT);
        check_model("saturated");

        // randomized traffic against the queue model
        cyc(1, 0, 0, 0, 0);
        check_model("rand reset");
        for (int i = 0; i < 3000; i++) begin
            logic [3:0] st;
            st = ($urandom_range(0, 2) == 0) ? 4'($urandom) : 4'd0;
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 2) != 0), M'($urandom), st);
            check_model($sformatf("rand%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
